// File: rtl/wb_ram_timer_responder_if.sv
// Wishbone classic (B3) bus bundle between an initiator and wb_ram_timer_responder.
//   adr   : word address          cyc   : cycle valid       stb : strobe
//   we    : 1 = write             sel   : byte-lane enables dat_w : write data
//   dat_r : read data (valid with ack)                      ack : transfer acknowledge
// master drives the request side, slave drives dat_r/ack.
interface wb_ram_timer_responder_if;
  logic [29:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output adr, cyc, stb, we, sel, dat_w, input dat_r, ack);
  modport slave  (input adr, cyc, stb, we, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_ram_timer_responder.sv
// Wishbone classic responder: word RAM plus an optional machine-timer window.
// Fixed latency: ack is high WAIT_STATES+1 cycles after a request is first seen.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : wb_ram_timer_responder_if.slave (adr/cyc/stb/we/sel/dat_w in, dat_r/ack out)
//   irq  : machine timer interrupt, registered
//
// Build option: define MTIMER_EN to include mtime/mtimecmp at TIMER_BASE
// (offsets 0..3 = mtime lo/hi, mtimecmp lo/hi) and the irq output. Without it
// the timer window decodes as unmapped and irq is tied low.
module wb_ram_timer_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [29:0] TIMER_BASE  = 30'h2000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  wb_ram_timer_responder_if.slave        bus,
  output logic                           irq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  WS = 2'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        ack_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          hit_ram;
  logic [AW-1:0] ram_idx;
  logic          wr_commit;
  logic [31:0]   rdata;

  assign hit_ram   = ({2'b00, adr_q} < DEPTH_WORDS);
  assign ram_idx   = adr_q[AW-1:0];
  // Writes land on the edge closing the ACK cycle, so dat_r in ACK shows the old value.
  assign wr_commit = (state_q == ST_ACK) && we_q;

  // Request FSM with registered ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (bus.cyc && bus.stb) begin
            adr_q <= bus.adr;
            we_q  <= bus.we;
            sel_q <= bus.sel;
            dat_q <= bus.dat_w;
            cnt_q <= WS;
            if (WS != 2'd0) begin
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.cyc) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_commit && hit_ram) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[ram_idx][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end

`ifdef MTIMER_EN
  logic        hit_tmr;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q;

  // RAM decode takes priority should the window ever fall inside the RAM range.
  assign hit_tmr = !hit_ram && (adr_q[29:2] == TIMER_BASE[29:2]);

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) begin
      r[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  // A written mtime half replaces its incremented value; the other half keeps
  // its normal increment.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr_commit && hit_tmr) begin
      case (adr_q[1:0])
        2'd0:    mtime_d[31:0]     = lane_merge(mtime_q[31:0],     dat_q, sel_q);
        2'd1:    mtime_d[63:32]    = lane_merge(mtime_q[63:32],    dat_q, sel_q);
        2'd2:    mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0],  dat_q, sel_q);
        default: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], dat_q, sel_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_d >= mtimecmp_d);
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    if (hit_ram) begin
      rdata = mem[ram_idx];
    end else if (hit_tmr) begin
      case (adr_q[1:0])
        2'd0:    rdata = mtime_q[31:0];
        2'd1:    rdata = mtime_q[63:32];
        2'd2:    rdata = mtimecmp_q[31:0];
        default: rdata = mtimecmp_q[63:32];
      endcase
    end
  end
`else
  logic unused_tmr_base;
  assign unused_tmr_base = ^TIMER_BASE;
  assign irq = 1'b0;

  always_comb begin
    rdata = '0;
    if (hit_ram) rdata = mem[ram_idx];
  end
`endif

  assign bus.ack   = ack_q;
  assign bus.dat_r = ack_q ? rdata : '0;

endmodule

// File: tb/tb_wb_ram_timer_responder.sv
module tb_wb_ram_timer_responder;

  localparam logic [29:0] TBASE = 30'h2000_0000;
  localparam int          NDUT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = '0;
  logic [29:0] adr = '0;
  logic [31:0] dat_w = '0;
  int          cur = 0;

  logic [NDUT-1:0] ack_v;
  logic [NDUT-1:0] irq_v;
  logic [31:0]     rd_v [NDUT];

  int cyc_cnt = 0;
  int ack_cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mem_m   [NDUT][16];
  bit          known_m [NDUT][16];
  logic [63:0] cmp_m   [NDUT];
  logic [63:0] mt_base [NDUT];
  int          mt_ack  [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // DUT 0/1/2 use WAIT_STATES 0/3/2; only the selected one sees cyc/stb.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    wb_ram_timer_responder_if bus_if ();
    assign bus_if.cyc   = cyc && (cur == g);
    assign bus_if.stb   = stb && (cur == g);
    assign bus_if.we    = we;
    assign bus_if.sel   = sel;
    assign bus_if.adr   = adr;
    assign bus_if.dat_w = dat_w;
    assign ack_v[g]     = bus_if.ack;
    assign rd_v[g]      = bus_if.dat_r;
    wb_ram_timer_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES(WS),
      .TIMER_BASE (TBASE)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if),
      .irq(irq_v[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mtime_at(input int d, input int c);
    return mt_base[d] + 64'(c - mt_ack[d] - 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int rel_cyc);
    for (int d = 0; d < NDUT; d++) begin
      cmp_m[d]   = '1;
      mt_base[d] = '0;
      mt_ack[d]  = rel_cyc - 1;
    end
  endtask

  // Caller is 1 time unit after a posedge with the addressed DUT idle.
  task automatic xfer(input int d, input logic w, input logic [29:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    cur = d; adr = a; we = w; sel = s; dat_w = wd; cyc = 1'b1; stb = 1'b1;
    lat = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack_v[d]) begin
        lat = i; rd = rd_v[d]; ack_cyc = cyc_cnt;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check($sformatf("latency_d%0d", d), 64'(lat), 64'(1 + ws_of(d)));
    @(posedge clk); #1;
    check($sformatf("ack_drop_d%0d", d), 64'(ack_v[d]), 64'd0);
  endtask

  task automatic do_write(input int d, input logic [29:0] a, input logic [3:0] s,
                          input logic [31:0] wd);
    logic [31:0] rd;
    logic [63:0] t;
    xfer(d, 1'b1, a, s, wd, rd);
    if (a < 30'd16) begin
      mem_m[d][a[3:0]] = bmerge(mem_m[d][a[3:0]], wd, s);
      if (s == 4'hF) known_m[d][a[3:0]] = 1'b1;
    end
`ifdef MTIMER_EN
    else if (a[29:2] == TBASE[29:2]) begin
      // mtime writes are issued with all lanes enabled.
      t = mtime_at(d, ack_cyc) + 64'd1;
      case (a[1:0])
        2'd0: begin t[31:0]  = wd; mt_base[d] = t; mt_ack[d] = ack_cyc; end
        2'd1: begin t[63:32] = wd; mt_base[d] = t; mt_ack[d] = ack_cyc; end
        2'd2: cmp_m[d][31:0]  = bmerge(cmp_m[d][31:0], wd, s);
        default: cmp_m[d][63:32] = bmerge(cmp_m[d][63:32], wd, s);
      endcase
    end
`endif
  endtask

  task automatic do_read(input int d, input logic [29:0] a, input logic [3:0] s,
                         output logic [31:0] rd);
    logic [31:0] exp;
    bit          cmp_it;
    logic [63:0] t;
    xfer(d, 1'b0, a, s, 32'h0, rd);
    exp = '0; cmp_it = 1'b1; t = '0;
    if (a < 30'd16) begin
      exp = mem_m[d][a[3:0]]; cmp_it = known_m[d][a[3:0]];
    end else if (a < 30'd1024) begin
      cmp_it = 1'b0;
    end else if (a[29:2] == TBASE[29:2]) begin
`ifdef MTIMER_EN
      t = mtime_at(d, ack_cyc);
      case (a[1:0])
        2'd0:    exp = t[31:0];
        2'd1:    exp = t[63:32];
        2'd2:    exp = cmp_m[d][31:0];
        default: exp = cmp_m[d][63:32];
      endcase
`endif
    end
    if (cmp_it) check($sformatf("rd_d%0d_a%08h", d, a), 64'(rd), 64'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [29:0] a;
    int          d, first, second, t0, rise, rel;
    bit          seen;

    for (int i = 0; i < NDUT; i++)
      for (int j = 0; j < 16; j++) known_m[i][j] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_ack_d%0d", i), 64'(ack_v[i]), 64'd0);
      check($sformatf("rst_dat_r_d%0d", i), 64'(rd_v[i]), 64'd0);
      check($sformatf("rst_irq_d%0d", i), 64'(irq_v[i]), 64'd0);
    end
    rst = 1'b0;
    model_reset(cyc_cnt);

    for (int i = 0; i < NDUT; i++)
      for (int j = 0; j < 16; j++) do_write(i, 30'(j), 4'hF, $urandom);

    // Zero-wait write then read
    do_write(0, 30'd5, 4'hF, 32'hDEADBEEF);
    do_read(0, 30'd5, 4'hF, rd);
    check("w0_readback", 64'(rd), 64'hDEADBEEF);

    // Single-lane write with three wait states
    do_write(1, 30'd7, 4'hF, 32'h11223344);
    do_write(1, 30'd7, 4'b0010, 32'h0000AB00);
    do_read(1, 30'd7, 4'h0, rd);
    check("w3_lane_merge", 64'(rd), 64'h1122AB44);

    // Abort: cyc dropped in WAIT
    do_write(2, 30'd3, 4'hF, 32'hA5A5_0003);
    cur = 2; adr = 30'd3; we = 1'b1; sel = 4'hF; dat_w = 32'h1234_5678; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ack_v[2]) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_ack", 64'(seen), 64'd0);
    do_read(2, 30'd3, 4'hF, rd);
    check("abort_old_data", 64'(rd), 64'hA5A5_0003);

    // Unmapped accesses; a write just above RAM must not alias into it
    do_read(0, 30'h0000_FFFF, 4'hF, rd);
    check("unmapped_zero", 64'(rd), 64'd0);
    do_write(0, 30'd1029, 4'hF, 32'hBAD0_BAD0);
    do_read(0, 30'd5, 4'hF, rd);

    // Strobe held through ack starts another transfer after one idle cycle
    cur = 1; adr = 30'd5; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    t0 = cyc_cnt; first = 0; second = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack_v[1]) begin
        if (first == 0) first = cyc_cnt - t0;
        else begin second = cyc_cnt - t0; break; end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    check("b2b_first", 64'(first), 64'(1 + ws_of(1)));
    check("b2b_second", 64'(second), 64'(2 * (1 + ws_of(1)) + 1));
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, NDUT - 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 30'($urandom_range(0, 15));
        6: a = 30'(1024 + $urandom_range(0, 1023));
        7: a = ($urandom_range(0, 1) == 0) ? 30'h0000_FFFF : 30'h3FFF_FFF0;
        default: a = TBASE + 30'($urandom_range(2, 3));
      endcase
      if ($urandom_range(0, 1) == 1) do_write(d, a, 4'($urandom), $urandom);
      else do_read(d, a, 4'($urandom), rd);
    end

`ifdef MTIMER_EN
    do_write(0, TBASE + 30'd3, 4'hF, 32'h0);
    do_write(0, TBASE + 30'd2, 4'hF, 32'd20);
    check("irq_set_cmp20", 64'(irq_v[0]), 64'd1);
    do_write(0, TBASE + 30'd0, 4'hF, 32'h0);
    check("irq_clear_mtime0", 64'(irq_v[0]), 64'd0);
    t0 = ack_cyc; rise = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (irq_v[0]) begin rise = cyc_cnt - t0; break; end
    end
    check("irq_rise_window", 64'(rise >= 20 && rise <= 22), 64'd1);
    do_read(0, TBASE + 30'd0, 4'hF, rd);
    do_read(0, TBASE + 30'd1, 4'hF, rd);
    check("irq_before_cmp_max", 64'(irq_v[0]), 64'd1);
    do_write(0, TBASE + 30'd2, 4'hF, 32'hFFFF_FFFF);
    check("irq_clear_cmp_max", 64'(irq_v[0]), 64'd0);
    do_read(0, TBASE + 30'd2, 4'h0, rd);
`else
    do_write(0, TBASE + 30'd2, 4'hF, 32'd5);
    do_read(0, TBASE + 30'd2, 4'hF, rd);
    check("no_timer_irq", 64'(irq_v), 64'd0);
`endif

    // Reset pulsed while a write waits
    cur = 1; adr = 30'd9; we = 1'b1; sel = 4'hF; dat_w = 32'hC0DE_0009; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ack", 64'(ack_v[1]), 64'd0);
    @(posedge clk); #1;
    check("rst_hold_ack", 64'(ack_v[1]), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    rel = cyc_cnt;
    model_reset(rel);
    check("rst_irq_after", 64'(irq_v), 64'd0);
    do_read(1, 30'd9, 4'hF, rd);
    do_read(1, TBASE + 30'd0, 4'hF, rd);
    do_read(1, TBASE + 30'd3, 4'hF, rd);
    do_write(1, 30'd9, 4'hF, 32'h600D_0009);
    do_read(1, 30'd9, 4'hF, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
